// File: rtl/player_move_scheduler_if.sv
// Wall-map query handshake between the player scheduler (master) and the maze map (slave).
interface player_move_scheduler_if;
  logic       req;
  logic [4:0] tx;
  logic [4:0] ty;
  logic       ack;
  logic       hit;

  modport master (output req, tx, ty, input ack, hit);
  modport slave  (input req, tx, ty, output ack, hit);
endinterface

// File: rtl/player_move_scheduler.sv
// Pac-Man player tile-grid sequencer: buffers key intent, paces steps with a tick divider,
// checks walls at tile-aligned positions and commits pixel steps to the sprite position.
module player_move_scheduler #(
  parameter int TILE        = 20,
  parameter int COLS        = 32,
  parameter int ROWS        = 24,
  parameter int SPEED       = 1,
  parameter int TICK_DIV    = 100000,
  parameter int START_TX    = 1,
  parameter int START_TY    = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w,
  input  logic                    a,
  input  logic                    s,
  input  logic                    d,
  input  logic                    enable,
  player_move_scheduler_if.master wall,
  output logic [9:0]              x,
  output logic [8:0]              y,
  output logic [1:0]              player_direction,
  output logic                    moving,
  output logic                    step
);
  // dir[1] selects the horizontal axis, dir[0] the positive direction; opposite = dir ^ 1
  localparam logic [1:0] DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3;
  localparam int OW = $clog2(TILE + 1);
  localparam int CW = $clog2(TICK_DIV);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ_PEND, REQ_CUR, STEP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [4:0]    tile_x, tile_y, tx_n, ty_n;
  logic [OW-1:0] off_x, off_y, ox_n, oy_n;
  logic [1:0]    heading, head_nxt, pend_dir, q_dir, key_dir, launch_dir;
  logic          pend_vld, key_any;
  logic          armed, oob, req;
  logic [TW-1:0] timer;
  logic [4:0]    req_tx, req_ty, nb_tx, nb_ty;
  logic          nb_oob, mid, resolved, hit_eff;
  logic          launch, commit, consume, stop;

  assign tick = enable && (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset)
    if (!reset)      cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;

  always_comb begin
    key_any = !w || !s || !a || !d;
    key_dir = DIR_RIGHT;
    if (!w)      key_dir = DIR_UP;
    else if (!s) key_dir = DIR_DOWN;
    else if (!a) key_dir = DIR_LEFT;
  end

  always_comb begin
    nb_tx  = tile_x;
    nb_ty  = tile_y;
    nb_oob = 1'b0;
    case (launch_dir)
      DIR_UP:   if (tile_y == '0)              nb_oob = 1'b1; else nb_ty = tile_y - 1'b1;
      DIR_DOWN: if (tile_y == 5'(ROWS - 1))    nb_oob = 1'b1; else nb_ty = tile_y + 1'b1;
      DIR_LEFT: if (tile_x == '0)              nb_oob = 1'b1; else nb_tx = tile_x - 1'b1;
      default:  if (tile_x == 5'(COLS - 1))    nb_oob = 1'b1; else nb_tx = tile_x + 1'b1;
    endcase
  end

  assign mid      = heading[1] ? (off_x != '0) : (off_y != '0);
  // a silent map (timeout) and an off-grid neighbour both count as a wall
  assign resolved = armed && (oob || wall.ack || timer == TW'(ACK_TIMEOUT - 1));
  assign hit_eff  = oob || !wall.ack || wall.hit;

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    launch_dir = heading;
    commit     = 1'b0;
    consume    = 1'b0;
    stop       = 1'b0;
    head_nxt   = heading;
    case (state)
      IDLE: if (tick) begin
        if (mid) begin
          if (pend_vld && pend_dir == (heading ^ 2'b01)) begin
            head_nxt = pend_dir;
            consume  = 1'b1;
          end
          state_nxt = STEP;
        end else if (pend_vld && pend_dir != heading) begin
          launch     = 1'b1;
          launch_dir = pend_dir;
          state_nxt  = REQ_PEND;
        end else begin
          launch    = 1'b1;
          state_nxt = REQ_CUR;
        end
      end
      REQ_PEND:
        if (!armed) begin
          launch     = 1'b1;
          launch_dir = q_dir;
        end else if (resolved) begin
          if (!hit_eff) begin
            head_nxt  = q_dir;
            consume   = 1'b1;
            state_nxt = STEP;
          end else state_nxt = REQ_CUR;
        end
      REQ_CUR:
        // entered unarmed after a blocked turn, so the request drops for a cycle first
        if (!armed) launch = 1'b1;
        else if (resolved) begin
          if (!hit_eff) state_nxt = STEP;
          else begin
            stop      = 1'b1;
            state_nxt = IDLE;
          end
        end
      default: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      heading  <= DIR_RIGHT;
      pend_vld <= 1'b0;
      pend_dir <= DIR_RIGHT;
    end else begin
      state   <= state_nxt;
      heading <= head_nxt;
      if (key_any) begin
        pend_vld <= 1'b1;
        pend_dir <= key_dir;
      end else if (consume) pend_vld <= 1'b0;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      armed  <= 1'b0;
      oob    <= 1'b0;
      req    <= 1'b0;
      timer  <= '0;
      req_tx <= '0;
      req_ty <= '0;
      q_dir  <= DIR_RIGHT;
    end else if (launch) begin
      armed <= 1'b1;
      oob   <= nb_oob;
      req   <= !nb_oob;
      timer <= '0;
      q_dir <= launch_dir;
      if (!nb_oob) begin
        req_tx <= nb_tx;
        req_ty <= nb_ty;
      end
    end else if (resolved) begin
      armed <= 1'b0;
      req   <= 1'b0;
    end else if (armed) timer <= timer + 1'b1;

  always_comb begin
    tx_n = tile_x;
    ty_n = tile_y;
    ox_n = off_x;
    oy_n = off_y;
    case (heading)
      DIR_RIGHT: if (off_x == OW'(TILE - SPEED)) begin tx_n = tile_x + 1'b1; ox_n = '0; end
                 else ox_n = off_x + OW'(SPEED);
      DIR_DOWN:  if (off_y == OW'(TILE - SPEED)) begin ty_n = tile_y + 1'b1; oy_n = '0; end
                 else oy_n = off_y + OW'(SPEED);
      DIR_LEFT:  if (off_x == '0) begin tx_n = tile_x - 1'b1; ox_n = OW'(TILE - SPEED); end
                 else ox_n = off_x - OW'(SPEED);
      default:   if (off_y == '0) begin ty_n = tile_y - 1'b1; oy_n = OW'(TILE - SPEED); end
                 else oy_n = off_y - OW'(SPEED);
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tile_x <= 5'(START_TX);
      tile_y <= 5'(START_TY);
      off_x  <= '0;
      off_y  <= '0;
      x      <= 10'(START_TX * TILE);
      y      <= 9'(START_TY * TILE);
      moving <= 1'b0;
      step   <= 1'b0;
    end else begin
      step <= commit;
      if (commit) begin
        tile_x <= tx_n;
        tile_y <= ty_n;
        off_x  <= ox_n;
        off_y  <= oy_n;
        x      <= 10'(int'(tx_n) * TILE + int'(ox_n));
        y      <= 9'(int'(ty_n) * TILE + int'(oy_n));
        moving <= 1'b1;
      end else if (stop) moving <= 1'b0;
    end

  assign wall.req         = req;
  assign wall.tx          = req_tx;
  assign wall.ty          = req_ty;
  assign player_direction = heading;
endmodule

// File: tb/tb_player_move_scheduler.sv
// Scoreboard bench: expected steps and wall queries are queued up front and popped as the DUT emits them.
module tb_player_move_scheduler;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  logic       clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic       w = 1'b1, a = 1'b1, s = 1'b1, d = 1'b1;
  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] dir;
  logic       moving, step;
  logic       mute = 1'b0;

  player_move_scheduler_if wall ();

  player_move_scheduler #(
    .TILE(20), .COLS(32), .ROWS(24), .SPEED(1), .TICK_DIV(4),
    .START_TX(1), .START_TY(1), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .w(w), .a(a), .s(s), .d(d), .enable(enable),
    .wall(wall), .x(x), .y(y), .player_direction(dir), .moving(moving), .step(step)
  );

  always #5 clk = ~clk;

  // map model: row 0 is solid wall, everything else open; ack one cycle after req
  always @(posedge clk) begin
    wall.ack <= wall.req && !wall.ack && !mute;
    wall.hit <= (wall.ty == 5'd0);
  end

  typedef struct { int x; int y; int dir; } step_t;
  typedef struct { int tx; int ty; } req_t;
  step_t step_q[$];
  req_t  req_q[$];
  int    n_chk = 0, n_fail = 0;
  int    req_run = 0, last_run = 0;
  bit    sb_on = 1'b0;
  logic  req_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_step(input int px, input int py, input int pd);
    step_t e;
    e.x = px; e.y = py; e.dir = pd;
    step_q.push_back(e);
  endtask

  task automatic push_req(input int tx, input int ty);
    req_t r;
    r.tx = tx; r.ty = ty;
    req_q.push_back(r);
  endtask

  always @(negedge clk) begin
    step_t e;
    req_t  r;
    if (sb_on) begin
      if (step) begin
        if (step_q.size() == 0) chk("extra_step", x, 32'hffff_ffff);
        else begin
          e = step_q.pop_front();
          chk("step_x", x, e.x);
          chk("step_y", y, e.y);
          chk("step_dir", dir, e.dir);
        end
      end
      if (wall.req && !req_prev) begin
        if (req_q.size() == 0) chk("extra_req", wall.tx, 32'hffff_ffff);
        else begin
          r = req_q.pop_front();
          chk("req_tx", wall.tx, r.tx);
          chk("req_ty", wall.ty, r.ty);
        end
      end
    end
    if (wall.req) req_run = req_prev ? req_run + 1 : 1;
    else if (req_prev) last_run = req_run;
    req_prev = wall.req;
  end

  task automatic wait_x(input int target, input int budget);
    int n = 0;
    while (x !== 10'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_x_%0d", target), x, target);
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (wall.req !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, wall.req, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d steps pending", step_q.size());
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", x, 20);
    chk("rst_y", y, 20);
    chk("rst_dir", dir, RIGHT);
    chk("rst_moving", moving, 0);
    chk("rst_step", step, 0);
    chk("rst_req", wall.req, 0);

    // reset in the middle of an unanswered REQ_CUR query
    mute = 1'b1; reset = 1'b1; enable = 1'b1;
    wait_req(1'b1, 20, "midreq_raised");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_req", wall.req, 0);
    chk("midrst_x", x, 20);
    chk("midrst_y", y, 20);
    chk("midrst_dir", dir, RIGHT);
    chk("midrst_moving", moving, 0);
    mute = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // full walk: right to 40, blocked turn up, right to 67, reverse, left to the grid edge
    for (int i = 21; i <= 40; i++) push_step(i, 20, RIGHT);
    push_req(2, 1); push_req(2, 0); push_req(3, 1);
    for (int i = 41; i <= 67; i++) push_step(i, 20, RIGHT);
    push_req(3, 0); push_req(4, 1);
    for (int i = 66; i >= 0; i--) push_step(i, 20, LEFT);
    push_req(2, 1); push_req(1, 1); push_req(0, 1);
    sb_on = 1'b1;
    d = 1'b0; enable = 1'b1;
    wait_x(21, 20);
    chk("moving_on", moving, 1);
    wait_x(39, 200);
    d = 1'b1; w = 1'b0;
    @(negedge clk);
    w = 1'b1;
    wait_x(67, 300);
    a = 1'b0;
    @(negedge clk);
    a = 1'b1;
    wait_x(0, 800);
    repeat (12) @(negedge clk);
    chk("edge_x", x, 0);
    chk("edge_moving", moving, 0);
    chk("edge_dir", dir, LEFT);
    chk("walk_steps_left", step_q.size(), 0);
    chk("walk_reqs_left", req_q.size(), 0);

    // turn request into a silent map: times out and is treated as a wall
    push_req(1, 1);
    mute = 1'b1; d = 1'b0;
    wait_req(1'b1, 20, "to_req_raised");
    d = 1'b1;
    wait_req(1'b0, 40, "to_req_dropped");
    enable = 1'b0;
    #1;
    chk("to_req_len", last_run, 15);
    repeat (10) @(negedge clk);
    chk("to_x", x, 0);
    chk("to_moving", moving, 0);
    chk("to_dir", dir, LEFT);
    chk("to_req_idle", wall.req, 0);
    chk("to_reqs_left", req_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
